// File: rtl/wb_multi_if.sv
// Writeback bus between the issue pipeline, the register file and the ECALL service agent.
// Lane i of every packed field sits at [i*WIDTH +: WIDTH]; lane 0 is the oldest.
interface wb_multi_if #(
   parameter int LANES   = 2,
   parameter int REGBITS = 5,
   parameter int LOGSIZE = 64,
   parameter int PCBITS  = 32
);
   logic [LANES-1:0]         in_valid;
   logic [LANES-1:0]         in_ld_or_alu;
   logic [LANES*LOGSIZE-1:0] in_lddata;
   logic [LANES*LOGSIZE-1:0] in_alures;
   logic [LANES*REGBITS-1:0] in_rd;
   logic [LANES-1:0]         in_is_ecall;
   logic [LANES*PCBITS-1:0]  in_pc;
   logic [8*LOGSIZE-1:0]     ecall_args;
   logic                     wb_flush;
   logic                     ecall_req;
   logic                     ecall_ack;
   logic [LOGSIZE-1:0]       ecall_result;
   logic [8*LOGSIZE-1:0]     ecall_arg_q;
   logic                     stall;
   logic [LANES-1:0]         wr_en;
   logic [LANES*LOGSIZE-1:0] wr_data;
   logic [LANES*REGBITS-1:0] wr_rd;
   logic                     ecall_flush;
   logic [PCBITS-1:0]        pc_after_flush;

   modport master (
      output in_valid, in_ld_or_alu, in_lddata, in_alures, in_rd, in_is_ecall, in_pc,
      output ecall_args, wb_flush, ecall_ack, ecall_result,
      input  ecall_req, ecall_arg_q, stall, wr_en, wr_data, wr_rd, ecall_flush, pc_after_flush
   );

   modport slave (
      input  in_valid, in_ld_or_alu, in_lddata, in_alures, in_rd, in_is_ecall, in_pc,
      input  ecall_args, wb_flush, ecall_ack, ecall_result,
      output ecall_req, ecall_arg_q, stall, wr_en, wr_data, wr_rd, ecall_flush, pc_after_flush
   );
endinterface

// File: rtl/wb_multi.sv
// Multi-lane writeback stage with ECALL hand-off: registered register-file writes,
// same-cycle WAW resolution, and a stall/commit sequence around each ECALL.
//
// state    | meaning
// IDLE     | normal writeback, lanes sampled every cycle
// WAIT_ACK | ECALL outstanding, pipeline stalled, waiting for service agent
// COMMIT   | one cycle: write result to a0, flush and redirect to PC+4
module wb_multi #(
   parameter int LANES   = 2,
   parameter int REGBITS = 5,
   parameter int LOGSIZE = 64,
   parameter int PCBITS  = 32
) (
   input  logic       clk,
   input  logic       rst,
   wb_multi_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, COMMIT} state_t;

   state_t state_q, state_d;

   logic [LANES-1:0]         wr_en_q, wr_en_d;
   logic [LANES*LOGSIZE-1:0] wr_data_q, wr_data_d;
   logic [LANES*REGBITS-1:0] wr_rd_q, wr_rd_d;
   logic                     ecall_req_q, ecall_req_d;
   logic                     stall_q, stall_d;
   logic                     ecall_flush_q, ecall_flush_d;
   logic [PCBITS-1:0]        pc_after_q, pc_after_d;
   logic [8*LOGSIZE-1:0]     arg_q, arg_d;
   logic [PCBITS-1:0]        ecall_pc_q, ecall_pc_d;

   logic [LANES-1:0]         ecall_lane;
   logic [LANES-1:0]         cand;
   logic [LANES-1:0]         en_calc;
   logic [LANES*LOGSIZE-1:0] data_calc;
   logic                     ecall_any;
   logic [PCBITS-1:0]        ecall_pc;

   // A lane is a write candidate unless it or an older lane is an ECALL; a candidate
   // loses to any younger candidate targeting the same register.
   always_comb begin
      ecall_lane = '0;
      cand       = '0;
      en_calc    = '0;
      data_calc  = '0;
      ecall_pc   = '0;
      ecall_any  = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         ecall_lane[i] = bus.in_valid[i] & bus.in_is_ecall[i] & ~bus.wb_flush;
         if (ecall_lane[i] && !ecall_any)
            ecall_pc = bus.in_pc[i*PCBITS +: PCBITS];
         ecall_any = ecall_any | ecall_lane[i];
         cand[i]   = bus.in_valid[i] & ~bus.wb_flush & ~ecall_any
                   & (bus.in_rd[i*REGBITS +: REGBITS] != '0);
         data_calc[i*LOGSIZE +: LOGSIZE] = bus.in_ld_or_alu[i] ? bus.in_lddata[i*LOGSIZE +: LOGSIZE]
                                                               : bus.in_alures[i*LOGSIZE +: LOGSIZE];
      end
      for (int i = 0; i < LANES; i++) begin
         en_calc[i] = cand[i];
         for (int j = 0; j < LANES; j++) begin
            if (j > i && cand[j] &&
                bus.in_rd[j*REGBITS +: REGBITS] == bus.in_rd[i*REGBITS +: REGBITS])
               en_calc[i] = 1'b0;
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      wr_en_d       = '0;
      wr_data_d     = wr_data_q;
      wr_rd_d       = wr_rd_q;
      ecall_req_d   = 1'b0;
      stall_d       = 1'b0;
      ecall_flush_d = 1'b0;
      pc_after_d    = pc_after_q;
      arg_d         = arg_q;
      ecall_pc_d    = ecall_pc_q;
      case (state_q)
         IDLE: begin
            wr_en_d   = en_calc;
            wr_data_d = data_calc;
            wr_rd_d   = bus.in_rd;
            if (ecall_any) begin
               state_d     = WAIT_ACK;
               arg_d       = bus.ecall_args;
               ecall_pc_d  = ecall_pc;
               ecall_req_d = 1'b1;
               stall_d     = 1'b1;
            end
         end
         WAIT_ACK: begin
            ecall_req_d = 1'b1;
            stall_d     = 1'b1;
            if (bus.ecall_ack && ecall_req_q) begin
               state_d                     = COMMIT;
               ecall_req_d                 = 1'b0;
               wr_en_d[0]                  = 1'b1;
               wr_rd_d[REGBITS-1:0]        = REGBITS'(10);
               wr_data_d[LOGSIZE-1:0]      = bus.ecall_result;
               ecall_flush_d               = 1'b1;
               pc_after_d                  = ecall_pc_q + PCBITS'(4);
            end
         end
         COMMIT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         wr_en_q       <= '0;
         wr_data_q     <= '0;
         wr_rd_q       <= '0;
         ecall_req_q   <= 1'b0;
         stall_q       <= 1'b0;
         ecall_flush_q <= 1'b0;
         pc_after_q    <= '0;
         arg_q         <= '0;
         ecall_pc_q    <= '0;
      end else begin
         state_q       <= state_d;
         wr_en_q       <= wr_en_d;
         wr_data_q     <= wr_data_d;
         wr_rd_q       <= wr_rd_d;
         ecall_req_q   <= ecall_req_d;
         stall_q       <= stall_d;
         ecall_flush_q <= ecall_flush_d;
         pc_after_q    <= pc_after_d;
         arg_q         <= arg_d;
         ecall_pc_q    <= ecall_pc_d;
      end
   end

   assign bus.wr_en          = wr_en_q;
   assign bus.wr_data        = wr_data_q;
   assign bus.wr_rd          = wr_rd_q;
   assign bus.ecall_req      = ecall_req_q;
   assign bus.stall          = stall_q;
   assign bus.ecall_flush    = ecall_flush_q;
   assign bus.pc_after_flush = pc_after_q;
   assign bus.ecall_arg_q    = arg_q;

endmodule

// File: doc/wb_multi.md
WB_MULTI -- requirements
Module: wb_multi

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): LANES, 2, writeback lanes per cycle (lane 0 oldest).
REQ-002 REGBITS, 5, register index width; LOGSIZE, 64, data width; PCBITS, 32, PC width.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- clk  in  1  sole clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  LANES  lane carries an instruction.
- in_ld_or_alu  in  LANES  1 selects load data, 0 selects ALU result.
- in_lddata  in  LANES*LOGSIZE  load data, lane i at bits [i*LOGSIZE +: LOGSIZE].
- in_alures  in  LANES*LOGSIZE  ALU result, packed as in_lddata.
- in_rd  in  LANES*REGBITS  destination register per lane.
- in_is_ecall  in  LANES  lane is an ECALL.
- in_pc  in  LANES*PCBITS  PC per lane.
- ecall_args  in  8*LOGSIZE  a7,a0..a6 snapshot, slot 0 = a7.
- wb_flush  in  1  kill current-cycle inputs.
- ecall_req  out  1  ECALL service request.
- ecall_ack  in  1  service done, ecall_result valid.
- ecall_result  in  LOGSIZE  value for a0.
- ecall_arg_q  out  8*LOGSIZE  latched ecall_args.
- stall  out  1  upstream must hold; inputs ignored.
- wr_en  out  LANES  register-file write enable per lane.
- wr_data  out  LANES*LOGSIZE  write data per lane.
- wr_rd  out  LANES*REGBITS  write address per lane.
- ecall_flush  out  1  one-cycle pipeline flush after ECALL.
- pc_after_flush  out  PCBITS  refetch PC.

Function
REQ-004 All outputs SHALL be registered; writeback latency SHALL be one cycle from input sample to wr_en.
REQ-005 FSM states SHALL be IDLE, WAIT_ACK, COMMIT.
REQ-006 In IDLE, lane i SHALL have wr_en[i] set next cycle iff in_valid[i], not wb_flush, in_rd[i] != 0, no ECALL in lanes 0..i, and no younger lane j>i writes the same rd.
REQ-007 wr_data[i] SHALL be in_lddata lane i if in_ld_or_alu[i] is 1, else in_alures lane i; wr_rd[i] = in_rd lane i.
REQ-008 ECALL detect: the lowest-index lane k with in_valid and in_is_ecall, not wb_flush, SHALL move IDLE->WAIT_ACK, latch ecall_args into ecall_arg_q and in_pc lane k, and suppress lanes >= k.
REQ-009 In WAIT_ACK, ecall_req and stall SHALL be 1, wr_en SHALL be 0, and data inputs and wb_flush SHALL be ignored.
REQ-010 ecall_ack SHALL be sampled only while ecall_req is 1; on ack, latch ecall_result and go to COMMIT.
REQ-011 COMMIT SHALL last one cycle: wr_en[0]=1, wr_rd[0]=10, wr_data[0]=latched result, other wr_en 0, ecall_flush=1, pc_after_flush = latched PC + 4 (mod 2^PCBITS), stall=1, ecall_req=0; then go to IDLE.
REQ-012 ecall_flush SHALL be 0 in all other cycles; pc_after_flush SHALL hold its value when not updated.
REQ-013 stall SHALL be 0 in IDLE.

Reset
REQ-014 On rst low, immediately (asynchronously) the state SHALL be IDLE and all outputs 0, including mid-ECALL; operation SHALL resume on the first clk edge after rst goes high.

Verification
REQ-015 Lanes 0,1 valid ALU, rd 3/4, alures 0x11/0x22 -> next cycle wr_en=11, wr_rd 3/4, wr_data 0x11/0x22.
REQ-016 Both lanes rd=5, lane0 load 0xAA, lane1 ALU 0xBB -> only wr_en[1], data 0xBB; rd=0 on a lane -> no write.
REQ-017 Lane0 ALU rd 7, lane1 ECALL pc 0x100 -> lane0 writes; ecall_req and stall 1; ack after 3 cycles with result 0x5 -> COMMIT: wr_rd[0]=10, data 0x5, ecall_flush 1, pc_after_flush 0x104; IDLE next.
REQ-018 wb_flush=1 with valid lanes -> wr_en all 0 next cycle; wb_flush during WAIT_ACK -> no effect.
REQ-019 rst low during WAIT_ACK -> ecall_req, stall and all outputs 0 without a clock edge; a following ack is ignored.
